// File: rtl/nn_pkg.sv
// Shared definitions for the layer scheduler: state encoding,
// default word width and a slice helper for flattened buses.
package nn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int RES_DEFAULT = 8;

  // LSB position of word idx in a bus of res-bit words
  function automatic int word_lsb(int idx, int res);
    return idx * res;
  endfunction

endpackage

// File: rtl/layer_output_bank.sv
// Output bank: N x RES registers, indexed write, sync clear.
// Ports: clk, reset, i_we, i_idx, i_data -> o_bank. Option: LAYER_RELU_EN.
module layer_output_bank
  import nn_pkg::*;
#(
  parameter int N   = 10,
  parameter int RES = RES_DEFAULT,
  parameter int AW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_idx,
  input  logic [RES-1:0]   i_data,
  output logic [N*RES-1:0] o_bank
);

  logic [N*RES-1:0] r_bank;
  logic [RES-1:0]   w_val;

`ifdef LAYER_RELU_EN
  // negative results clamp to zero at capture
  assign w_val = i_data[RES-1] ? '0 : i_data;
`else
  assign w_val = i_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_we && i_idx == AW'(i))
          r_bank[word_lsb(i, RES) +: RES] <= w_val;
      end
    end
  end

  assign o_bank = r_bank;

endmodule

// File: rtl/layer_scheduler.sv
// Steps one shared neuron through all neurons of a layer.
// Ports: layer ctl, weight mem, neuron bus, layer_output. Option: LAYER_RELU_EN.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int input_data_size = 4,
  parameter int resolution      = RES_DEFAULT,
  parameter int num_neurons     = 10,
  parameter int NEURON_LATENCY  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                layer_start,
  input  logic [resolution*input_data_size-1:0] input_data,
  output logic                                layer_busy,
  output logic                                layer_done,
  output logic                                wmem_rd_en,
  output logic [((num_neurons > 1) ? $clog2(num_neurons) : 1)-1:0] wmem_addr,
  input  logic [resolution*input_data_size-1:0] wmem_weight,
  input  logic [resolution-1:0]               wmem_bias,
  output logic                                neuron_start,
  output logic [resolution*input_data_size-1:0] neuron_input,
  output logic [resolution*input_data_size-1:0] neuron_weight,
  output logic [resolution-1:0]               neuron_bias,
  input  logic [resolution-1:0]               neuron_output,
  output logic [resolution*num_neurons-1:0]   layer_output
);

  localparam int DW = resolution * input_data_size;
  localparam int AW = (num_neurons > 1) ? $clog2(num_neurons) : 1;
  localparam int CW = $clog2(NEURON_LATENCY + 1);

  state_t          r_state, w_next;
  logic [AW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_input, r_weight;
  logic [resolution-1:0] r_bias;
  logic            w_last_wait, w_last_idx;

  assign w_last_wait = (r_state == S_WAIT) && (r_cnt == CW'(1));
  assign w_last_idx  = (r_idx == AW'(num_neurons - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (layer_start) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:
        if (w_last_wait)
          w_next = w_last_idx ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    layer_busy   = (r_state != S_IDLE);
    layer_done   = (r_state == S_DONE);
    wmem_rd_en   = (r_state == S_FETCH);
    wmem_addr    = (r_state == S_FETCH) ? r_idx : '0;
    // counter still holds its load value in the first WAIT cycle
    neuron_start = (r_state == S_WAIT) &&
                   (r_cnt == CW'(NEURON_LATENCY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_input  <= '0;
      r_weight <= '0;
      r_bias   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (layer_start) begin
            r_input <= input_data;
            r_idx   <= '0;
          end
        S_LOAD: begin
          r_weight <= wmem_weight;
          r_bias   <= wmem_bias;
          r_cnt    <= CW'(NEURON_LATENCY);
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_last_wait && !w_last_idx)
            r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign neuron_input  = r_input;
  assign neuron_weight = r_weight;
  assign neuron_bias   = r_bias;

  layer_output_bank #(
    .N   (num_neurons),
    .RES (resolution),
    .AW  (AW)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_last_wait),
    .i_idx  (r_idx),
    .i_data (neuron_output),
    .o_bank (layer_output)
  );

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: ROM weight memory, stub neuron,
// directed + random runs against a per-layer reference model.
module tb_layer_scheduler;

  localparam int IDS = 4;
  localparam int RES = 8;
  localparam int N   = 3;
  localparam int LAT = 4;
  localparam int DW  = RES * IDS;
  localparam int DONE_CYC = N * (LAT + 2) + 1;

  logic            clk = 1'b0;
  logic            reset, layer_start;
  logic [DW-1:0]   input_data, wmem_weight, neuron_input, neuron_weight;
  logic            layer_busy, layer_done, wmem_rd_en, neuron_start;
  logic [1:0]      wmem_addr;
  logic [RES-1:0]  wmem_bias, neuron_bias, neuron_output;
  logic [N*RES-1:0] layer_output;

  logic [DW-1:0]   rom_w [N];
  logic [RES-1:0]  rom_b [N];

  int nchk = 0;
  int nerr = 0;
  int ns_cnt = 0;
  int wt_bad = 0;
  logic [1:0] addr_q[$];

  always #5 clk = ~clk;

  layer_scheduler #(
    .input_data_size (IDS),
    .resolution      (RES),
    .num_neurons     (N),
    .NEURON_LATENCY  (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .layer_start   (layer_start),
    .input_data    (input_data),
    .layer_busy    (layer_busy),
    .layer_done    (layer_done),
    .wmem_rd_en    (wmem_rd_en),
    .wmem_addr     (wmem_addr),
    .wmem_weight   (wmem_weight),
    .wmem_bias     (wmem_bias),
    .neuron_start  (neuron_start),
    .neuron_input  (neuron_input),
    .neuron_weight (neuron_weight),
    .neuron_bias   (neuron_bias),
    .neuron_output (neuron_output),
    .layer_output  (layer_output)
  );

  // weight memory: one-cycle read latency
  always @(posedge clk) begin
    if (wmem_rd_en) begin
      wmem_weight <= rom_w[wmem_addr];
      wmem_bias   <= rom_b[wmem_addr];
    end
  end

  // stub neuron: returns its bias two cycles after start
  logic r_d1;
  always @(posedge clk) begin
    if (reset) begin
      r_d1          <= 1'b0;
      neuron_output <= '0;
    end else begin
      r_d1 <= neuron_start;
      if (r_d1) neuron_output <= neuron_bias;
    end
  end

  always @(negedge clk) begin
    if (neuron_start) begin
      if (ns_cnt < N &&
          (neuron_weight !== rom_w[ns_cnt] ||
           neuron_bias !== rom_b[ns_cnt]))
        wt_bad++;
      ns_cnt++;
    end
    if (wmem_rd_en) addr_q.push_back(wmem_addr);
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected bank: each slot is its neuron's bias (stub), optionally ReLU'd
  function automatic logic [N*RES-1:0] model();
    logic [N*RES-1:0] m;
    logic [RES-1:0] b;
    m = '0;
    for (int i = 0; i < N; i++) begin
      b = rom_b[i];
`ifdef LAYER_RELU_EN
      if (b[RES-1]) b = '0;
`endif
      m[i*RES +: RES] = b;
    end
    return m;
  endfunction

  task automatic run(input logic [DW-1:0] din, input bit pulses);
    int done_cyc;
    bit in_ok;
    logic [5:0] aseq;
    ns_cnt = 0;
    wt_bad = 0;
    addr_q.delete();
    in_ok = 1'b1;
    done_cyc = -1;
    input_data = din;
    layer_start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      layer_start = pulses && (k == 5 || k == DONE_CYC);
      if (pulses && k == 8) input_data = ~din;
      if (neuron_input !== din) in_ok = 1'b0;
      if (layer_done) begin
        done_cyc = k;
        break;
      end
    end
    aseq = '1;
    if (addr_q.size() == N) aseq = {addr_q[2], addr_q[1], addr_q[0]};
    check("done_cycle", 64'(done_cyc), 64'(DONE_CYC));
    check("layer_output", 64'(layer_output), 64'(model()));
    check("start_count", 64'(ns_cnt), 64'(N));
    check("addr_seq", {32'(addr_q.size()), 32'(aseq)},
          {32'(N), 32'(6'b10_01_00)});
    check("input_stable", 64'(in_ok), 64'd1);
    check("weights_at_start", 64'(wt_bad), 64'd0);
    @(negedge clk);
    layer_start = 1'b0;
    check("idle_after_done", {62'd0, layer_busy, layer_done}, 64'd0);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1;
    layer_start = 1'b0;
    input_data = '0;
    rom_b[0] = 8'h05;
    rom_b[1] = 8'hFD;
    rom_b[2] = 8'h07;
    for (int i = 0; i < N; i++) rom_w[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_ctl", {59'd0, layer_busy, layer_done, wmem_rd_en,
          neuron_start, 1'b0}, 64'd0);
    check("rst_addr", 64'(wmem_addr), 64'd0);
    check("rst_input", 64'(neuron_input), 64'd0);
    check("rst_wb", {24'd0, neuron_weight, neuron_bias}, 64'd0);
    check("rst_out", 64'(layer_output), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_rd", {62'd0, layer_busy, wmem_rd_en}, 64'd0);

    run(32'h80030100, 1'b0);
`ifdef LAYER_RELU_EN
    check("plan_output", 64'(layer_output), 64'h070005);
`else
    check("plan_output", 64'(layer_output), 64'h07FD05);
`endif
    run(32'h12345678, 1'b1);
    run(32'h80030100, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        rom_w[i] = $urandom;
        rom_b[i] = 8'($urandom);
      end
      run($urandom, 1'b0);
    end

    // reset in the second WAIT cycle of neuron 1 (cycle 10)
    input_data = 32'hA5A5A5A5;
    layer_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      layer_start = 1'b0;
    end
    check("busy_before_rst", 64'(layer_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 64'(layer_busy), 64'd0);
    check("rst_mid_out", 64'(layer_output), 64'd0);
    check("rst_mid_input", 64'(neuron_input), 64'd0);
    reset = 1'b0;
    ns_cnt = 0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (layer_done) dcnt++;
    end
    check("rst_no_start", 64'(ns_cnt), 64'd0);
    check("rst_no_done", 64'(dcnt), 64'd0);
    run(32'hA5A5A5A5, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
